// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: issue/collect initiator for the handshake divider (opdiv).
// Accepts DIV/DIVU/REM/REMU, resolves divide-by-zero and signed overflow locally,
// sends unsigned magnitudes to the divider, sign-corrects and returns a tagged result.
// Optional feature macro: DIV_RESULT_CACHE_EN (one-entry result cache).
// Ports:
//   clock, nreset        : clock (rising edge), synchronous active-low reset
//   flush_i              : kill the in-flight operation
//   req_*                : request channel (op, rs1, rs2, tag) with valid/ready
//   div_valid_o/ready_i  : operand channel to divider (div_a_o, div_b_o, div_signed_o)
//   div_valid_i/ready_o  : result channel from divider (div_quot_i, div_rem_i)
//   rsp_*                : response channel (data, tag) with valid/ready
module div_issue_ctrl #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned TAG_W = 5
) (
   input  logic             clock,
   input  logic             nreset,
   input  logic             flush_i,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic [1:0]       req_op_i,
   input  logic [WIDTH-1:0] req_rs1_i,
   input  logic [WIDTH-1:0] req_rs2_i,
   input  logic [TAG_W-1:0] req_tag_i,
   output logic             div_valid_o,
   input  logic             div_ready_i,
   output logic [WIDTH-1:0] div_a_o,
   output logic [WIDTH-1:0] div_b_o,
   output logic             div_signed_o,
   input  logic             div_valid_i,
   output logic             div_ready_o,
   input  logic [WIDTH-1:0] div_quot_i,
   input  logic [WIDTH-1:0] div_rem_i,
   output logic             rsp_valid_o,
   input  logic             rsp_ready_i,
   output logic [WIDTH-1:0] rsp_data_o,
   output logic [TAG_W-1:0] rsp_tag_o
);

   localparam int unsigned MSB = WIDTH - 1;
   localparam logic [WIDTH-1:0] MIN_V  = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] ONES_V = '1;

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_DRAIN} state_t;

   function automatic logic [WIDTH-1:0] neg_f(input logic [WIDTH-1:0] x);
      return (~x) + WIDTH'(1);
   endfunction

   state_t           state_q, state_d;
   logic             live_q;
   logic             killed_q, killed_d;
   logic             is_rem_q, is_rem_d;
   logic             qneg_q, qneg_d;
   logic             rneg_q, rneg_d;
   logic [WIDTH-1:0] div_a_q, div_a_d, div_b_q, div_b_d;
   logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
   logic             div_valid_q, div_valid_d;
   logic             div_ready_q, div_ready_d;
   logic             rsp_valid_q, rsp_valid_d;

   logic             req_signed_c, accept_c, special_c, fill_c;
   logic [WIDTH-1:0] abs1_c, abs2_c, special_data_c, quot_fix_c, rem_fix_c;
   logic             cache_hit_c;
   logic [WIDTH-1:0] cache_quot_c, cache_rem_c;

   // live_q keeps req_ready_o low while reset is held
   assign req_ready_o  = live_q && (state_q == S_IDLE) && !flush_i;
   assign accept_c     = req_ready_o && req_valid_i;
   assign div_valid_o  = div_valid_q;
   assign div_ready_o  = div_ready_q;
   assign rsp_valid_o  = rsp_valid_q;
   assign div_a_o      = div_a_q;
   assign div_b_o      = div_b_q;
   assign rsp_data_o   = rsp_data_q;
   assign rsp_tag_o    = rsp_tag_q;
   assign div_signed_o = 1'b0;
   assign fill_c       = (state_q == S_WAIT) && div_valid_i && !flush_i;

   // Operand magnitudes, special-case detection and result sign correction
   always_comb begin
      req_signed_c   = ~req_op_i[0];
      abs1_c         = (req_signed_c && req_rs1_i[MSB]) ? neg_f(req_rs1_i) : req_rs1_i;
      abs2_c         = (req_signed_c && req_rs2_i[MSB]) ? neg_f(req_rs2_i) : req_rs2_i;
      special_c      = 1'b0;
      special_data_c = '0;
      if (req_rs2_i == '0) begin
         special_c      = 1'b1;
         special_data_c = req_op_i[1] ? req_rs1_i : ONES_V;
      end else if (req_signed_c && (req_rs1_i == MIN_V) && (req_rs2_i == ONES_V)) begin
         special_c      = 1'b1;
         special_data_c = req_op_i[1] ? '0 : MIN_V;
      end
      quot_fix_c = qneg_q ? neg_f(div_quot_i) : div_quot_i;
      rem_fix_c  = (rneg_q && (div_rem_i != '0)) ? neg_f(div_rem_i) : div_rem_i;
   end

`ifdef DIV_RESULT_CACHE_EN
   logic             cache_vld_q, cache_vld_d;
   logic             cache_sgn_q, cache_sgn_d;
   logic [WIDTH-1:0] cache_rs1_q, cache_rs1_d, cache_rs2_q, cache_rs2_d;
   logic [WIDTH-1:0] cache_quot_q, cache_quot_d, cache_rem_q, cache_rem_d;
   logic             key_sgn_q, key_sgn_d;
   logic [WIDTH-1:0] key_rs1_q, key_rs1_d, key_rs2_q, key_rs2_d;

   // Key of the in-flight request is latched on accept, written to the cache on completion
   always_comb begin
      key_sgn_d    = key_sgn_q;
      key_rs1_d    = key_rs1_q;
      key_rs2_d    = key_rs2_q;
      cache_vld_d  = cache_vld_q;
      cache_sgn_d  = cache_sgn_q;
      cache_rs1_d  = cache_rs1_q;
      cache_rs2_d  = cache_rs2_q;
      cache_quot_d = cache_quot_q;
      cache_rem_d  = cache_rem_q;
      if (accept_c) begin
         key_sgn_d = req_signed_c;
         key_rs1_d = req_rs1_i;
         key_rs2_d = req_rs2_i;
      end
      if (fill_c) begin
         cache_vld_d  = 1'b1;
         cache_sgn_d  = key_sgn_q;
         cache_rs1_d  = key_rs1_q;
         cache_rs2_d  = key_rs2_q;
         cache_quot_d = quot_fix_c;
         cache_rem_d  = rem_fix_c;
      end
      cache_hit_c  = cache_vld_q && (cache_sgn_q == req_signed_c) &&
                     (cache_rs1_q == req_rs1_i) && (cache_rs2_q == req_rs2_i);
      cache_quot_c = cache_quot_q;
      cache_rem_c  = cache_rem_q;
   end

   always_ff @(posedge clock) begin
      if (!nreset) begin
         key_sgn_q    <= 1'b0;
         key_rs1_q    <= '0;
         key_rs2_q    <= '0;
         cache_vld_q  <= 1'b0;
         cache_sgn_q  <= 1'b0;
         cache_rs1_q  <= '0;
         cache_rs2_q  <= '0;
         cache_quot_q <= '0;
         cache_rem_q  <= '0;
      end else begin
         key_sgn_q    <= key_sgn_d;
         key_rs1_q    <= key_rs1_d;
         key_rs2_q    <= key_rs2_d;
         cache_vld_q  <= cache_vld_d;
         cache_sgn_q  <= cache_sgn_d;
         cache_rs1_q  <= cache_rs1_d;
         cache_rs2_q  <= cache_rs2_d;
         cache_quot_q <= cache_quot_d;
         cache_rem_q  <= cache_rem_d;
      end
   end
`else
   assign cache_hit_c  = 1'b0;
   assign cache_quot_c = '0;
   assign cache_rem_c  = '0;
`endif

   // Next-state and registered-output logic
   always_comb begin
      state_d    = state_q;
      killed_d   = killed_q;
      is_rem_d   = is_rem_q;
      qneg_d     = qneg_q;
      rneg_d     = rneg_q;
      div_a_d    = div_a_q;
      div_b_d    = div_b_q;
      rsp_data_d = rsp_data_q;
      rsp_tag_d  = rsp_tag_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept_c) begin
               killed_d  = 1'b0;
               is_rem_d  = req_op_i[1];
               qneg_d    = req_signed_c && (req_rs1_i[MSB] ^ req_rs2_i[MSB]);
               rneg_d    = req_signed_c && req_rs1_i[MSB];
               div_a_d   = abs1_c;
               div_b_d   = abs2_c;
               rsp_tag_d = req_tag_i;
               if (special_c) begin
                  rsp_data_d = special_data_c;
                  state_d    = S_RESP;
               end else if (cache_hit_c) begin
                  rsp_data_d = req_op_i[1] ? cache_rem_c : cache_quot_c;
                  state_d    = S_RESP;
               end else begin
                  state_d = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            // operands stay offered even when killed; the divider result is drained
            if (flush_i) killed_d = 1'b1;
            if (div_ready_i) state_d = (killed_q || flush_i) ? S_DRAIN : S_WAIT;
         end
         S_WAIT: begin
            if (div_valid_i) begin
               if (flush_i) begin
                  state_d = S_IDLE;
               end else begin
                  rsp_data_d = is_rem_q ? rem_fix_c : quot_fix_c;
                  state_d    = S_RESP;
               end
            end else if (flush_i) begin
               state_d = S_DRAIN;
            end
         end
         S_RESP: begin
            if (flush_i || rsp_ready_i) state_d = S_IDLE;
         end
         S_DRAIN: begin
            if (div_valid_i) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      div_valid_d = (state_d == S_ISSUE);
      div_ready_d = (state_d == S_WAIT) || (state_d == S_DRAIN);
      rsp_valid_d = (state_d == S_RESP);
   end

   // State and output registers
   always_ff @(posedge clock) begin
      if (!nreset) begin
         state_q     <= S_IDLE;
         live_q      <= 1'b0;
         killed_q    <= 1'b0;
         is_rem_q    <= 1'b0;
         qneg_q      <= 1'b0;
         rneg_q      <= 1'b0;
         div_a_q     <= '0;
         div_b_q     <= '0;
         rsp_data_q  <= '0;
         rsp_tag_q   <= '0;
         div_valid_q <= 1'b0;
         div_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         live_q      <= 1'b1;
         killed_q    <= killed_d;
         is_rem_q    <= is_rem_d;
         qneg_q      <= qneg_d;
         rneg_q      <= rneg_d;
         div_a_q     <= div_a_d;
         div_b_q     <= div_b_d;
         rsp_data_q  <= rsp_data_d;
         rsp_tag_q   <= rsp_tag_d;
         div_valid_q <= div_valid_d;
         div_ready_q <= div_ready_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

endmodule

// File: doc/div_issue_ctrl.md
# div_issue_ctrl

- Issue/collect initiator for the handshake divider (`opdiv`) in the M-extension execute path.
- Accepts decoded DIV/DIVU/REM/REMU requests from the pipeline and resolves RISC-V special cases locally.
- Drives the divider with unsigned magnitudes over its valid/ready interface, then applies sign correction and returns a tagged result.

## Interface
Parameters:
- WIDTH, 32, operand/result width
- TAG_W, 5, request tag width (destination register)

Ports:
- clock  in  1  sole clock, rising edge
- nreset  in  1  reset, synchronous, active-low
- flush_i  in  1  kill in-flight operation
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request ready
- req_op_i  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- req_rs1_i  in  WIDTH  dividend
- req_rs2_i  in  WIDTH  divisor
- req_tag_i  in  TAG_W  tag
- div_valid_o  out  1  operands valid to divider (`in_valid_i`)
- div_ready_i  in  1  divider accepts (`in_ready_o`)
- div_a_o  out  WIDTH  |dividend|
- div_b_o  out  WIDTH  |divisor|
- div_signed_o  out  1  divider `signal_division`, constant 0
- div_valid_i  in  1  divider result valid (`out_valid_o`)
- div_ready_o  out  1  result ready to divider (`out_ready_i`)
- div_quot_i  in  WIDTH  unsigned quotient
- div_rem_i  in  WIDTH  unsigned remainder
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response ready
- rsp_data_o  out  WIDTH  final quotient or remainder
- rsp_tag_o  out  TAG_W  tag of the response

## Operation
States: IDLE, ISSUE, WAIT, RESP, DRAIN.

- IDLE:
  - req_ready_o = !flush_i.
  - On accept, register op, operands, tag, sign_q = signed & (rs1[MSB]^rs2[MSB]), sign_r = signed & rs1[MSB].
  - Magnitudes: two's-complement negate when signed and MSB set. 0x80000000 maps to 0x80000000 unsigned.
  - Special cases go to RESP with result precomputed:
    - Divisor 0: DIV/DIVU = all-ones; REM/REMU = dividend.
    - Signed overflow 0x80000000 / 0xFFFFFFFF: DIV = 0x80000000, REM = 0.
  - All other requests go to ISSUE.
- ISSUE:
  - div_valid_o = 1, operands held stable.
  - On div_ready_i go to WAIT, or DRAIN if killed.
- WAIT:
  - div_ready_o = 1.
  - On div_valid_i capture div_quot_i/div_rem_i and select one by op.
  - Negate the quotient when sign_q; negate the remainder when sign_r and it is nonzero.
  - Then go to RESP.
- RESP: rsp_valid_o = 1 with data/tag stable until rsp_ready_i, then IDLE.
- DRAIN: div_ready_o = 1; on div_valid_i discard the result and go to IDLE.
- flush_i behaviour:
  - IDLE: no effect; any request that cycle is not accepted.
  - ISSUE: sets killed; div_valid_o stays high until accepted.
  - WAIT: go to DRAIN.
  - RESP: drop rsp_valid_o next cycle, go to IDLE.
  - DRAIN: no effect.

## Timing
- Reset (nreset low at a clock edge), all outputs 0:
  - req_ready_o, div_valid_o, div_ready_o, rsp_valid_o = 0.
  - Data/tag outputs = 0; state = IDLE; cache invalid.
- Reset mid-operation returns to IDLE immediately. The divider shares nreset, so no stale result arrives.
- Fast path (special case or cache hit): accept at cycle N, rsp_valid_o at N+1.
- Divider path: accept N, div_valid_o at N+1. Divider accept at M puts WAIT at M+1. div_valid_i at K gives rsp_valid_o at K+1.
- One operation in flight; req_ready_o is low outside IDLE.
- valid never drops before its handshake completes, except rsp_valid_o on flush.

## Configuration
- DIV_RESULT_CACHE_EN defined: one-entry cache of {rs1, rs2, signed} → corrected {quotient, remainder}.
  - Filled on every completed, non-killed divider operation.
  - A matching request (e.g. DIV followed by REM on the same operands) goes to RESP at N+1 without the divider.
  - Cleared only by reset.
- Undefined: no cache; every non-special request uses the divider.

## Test plan
- DIVU 0x80000000 / 9565 → rsp_data_o = 224514. REMU with the same operands → 7238.
- DIV -2147483648 / -9565 → 224514; REM → -7238 (0xFFFFE3BA). DIV -7 / 2 → -3; REM → -1.
- DIV 7 / 0 → 0xFFFFFFFF at N+1 with no div_valid_o; REM 7 / 0 → 7. DIV 0x80000000 / -1 → 0x80000000; REM → 0.
- flush_i asserted in WAIT:
  - div_ready_o stays high and the result is consumed with no rsp_valid_o.
  - Next request accepted after DRAIN → IDLE.
- Backpressure: rsp_ready_i low for 5 cycles → rsp_valid_o and rsp_data_o hold, req_ready_o = 0. nreset low mid-WAIT → all outputs 0 next cycle.
- With DIV_RESULT_CACHE_EN: DIV 100/7 → 14, then REM 100/7 → 2 at N+1, with div_valid_o never asserted.
